// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply or restoring divide,
// followed by one sign-fix cycle that commits the result to HI/LO.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] write_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  iter_cnt;
  logic [63:0] acc;
  logic [31:0] opnd_b;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Handshake: start is accepted only in IDLE on a rising edge; done pulses for one
  // cycle once HI/LO hold the new result. Nothing is queued while busy.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (iter_cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed ops work on magnitudes; the sign is restored in FIX.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && operand_a[31]) ? -operand_a : operand_a;
    b_mag     = (signed_op && operand_b[31]) ? -operand_b : operand_b;
  end

  // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    rem_sh   = acc[63:31];
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_b};
    if (!is_div)
      acc_step = {mul_sum, acc[31:1]};
    else if (div_diff[33])
      acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
    else
      acc_step = {div_diff[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
    if (div_zero) quo_fix = 32'hFFFF_FFFF;
    if (is_div) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= 5'd0;
      acc      <= 64'd0;
      opnd_b   <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        iter_cnt <= 5'd0;
        acc      <= {32'd0, a_mag};
        opnd_b   <= b_mag;
        is_div   <= op[1];
        neg_res  <= signed_op & (operand_a[31] ^ operand_b[31]);
        neg_rem  <= signed_op & operand_a[31];
        div_zero <= op[1] & (operand_b == 32'd0);
      end
    end else if (state == CALC) begin
      iter_cnt <= iter_cnt + 5'd1;
      acc      <= acc_step;
    end
  end

  // HI/LO: result commit at FIX->IDLE, MTHI/MTLO only in IDLE and only without start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == IDLE && !start) begin
        if (write_hi) hi <= write_data;
        if (write_lo) lo <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table for results and timing, plus
// hand sequences for MTHI/MTLO, ignored start/writes while busy, and mid-op reset.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  mul_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .write_data (write_data),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  int n_cmp;
  int n_bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit wr_at_start, input bit disturb);
    int busy_cnt;
    int hold_bad;
    logic [63:0] exp;
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    if (wr_at_start) begin
      write_hi = 1'b1;
      write_lo = 1'b1;
      write_data = 32'hDEAD_BEEF;
    end
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    start = 1'b0;
    write_hi = 1'b0;
    write_lo = 1'b0;
    op = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
    busy_cnt = 0;
    hold_bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo) hold_bad++;
      if (disturb && i == 5) begin
        start = 1'b1;
        write_lo = 1'b1;
        write_data = 32'h1234_5678;
        operand_a = 32'd9;
        operand_b = 32'd9;
      end else begin
        start = 1'b0;
        write_lo = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, "_hold_while_busy"}, 64'(hold_bad), 64'd0);
    exp = exp_q.pop_front();
    check({name, "_done"}, {62'd0, busy, done}, 64'd1);
    check({name, "_result"}, {hi, lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(negedge clk);
    check({name, "_done_cleared"}, {63'd0, done}, 64'd0);
    if (disturb) begin
      int extra;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        if (done !== 1'b0 || busy !== 1'b0) extra++;
        @(negedge clk);
      end
      check({name, "_no_second_op"}, 64'(extra), 64'd0);
      check({name, "_lo_kept"}, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[7]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780};
    vecs[11] = '{OP_MULT,  32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0};

    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    operand_a = 32'd0;
    operand_b = 32'd0;
    write_hi = 1'b0;
    write_lo = 1'b0;
    write_data = 32'd0;
    #1;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // start is applied for the very first rising edge after release
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);

    // MTHI alone, MTLO alone, then both together
    write_hi = 1'b1;
    write_data = 32'hA5A5_A5A5;
    @(negedge clk);
    write_hi = 1'b0;
    m_hi = 32'hA5A5_A5A5;
    check("mthi", {hi, lo}, {m_hi, m_lo});
    write_lo = 1'b1;
    write_data = 32'h0F0F_0F0F;
    @(negedge clk);
    write_lo = 1'b0;
    m_lo = 32'h0F0F_0F0F;
    check("mtlo", {hi, lo}, {m_hi, m_lo});
    write_hi = 1'b1;
    write_lo = 1'b1;
    write_data = 32'h3C3C_3C3C;
    @(negedge clk);
    write_hi = 1'b0;
    write_lo = 1'b0;
    m_hi = 32'h3C3C_3C3C;
    m_lo = 32'h3C3C_3C3C;
    check("mthi_mtlo", {hi, lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    check("idle_hold", {hi, lo}, {m_hi, m_lo});

    // start wins over same-cycle writes; busy hold check catches a stray write
    run_op("start_vs_write", OP_DIVU, 32'd50, 32'd8, 32'd2, 32'd6, 1'b1, 1'b0);
    // start and MTLO during CALC are both ignored
    run_op("calc_disturb", OP_MULTU, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 1'b1);

    // reset at CALC cycle 10
    start = 1'b1;
    op = OP_MULTU;
    operand_a = 32'hFFFF_FFFF;
    operand_b = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_regs", {hi, lo}, 64'd0);
    check("async_reset_flags", {62'd0, busy, done}, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
        if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stray++;
        @(negedge clk);
      end
      check("no_done_after_reset", 64'(stray), 64'd0);
    end
    run_op("post_reset_multu", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
